// File: rtl/instr_queue.sv
// Circular instruction queue between LC-3b fetch and decode.
// The head entry is presented with its decoded IR fields; flush and reset clear all entries.
module instr_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [15:0]              enq_instr,
  input  logic [PC_WIDTH-1:0]      enq_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [15:0]              deq_instr,
  output logic [PC_WIDTH-1:0]      deq_pc,
  output logic [3:0]               opcode,
  output logic [2:0]               dest,
  output logic [2:0]               sr1,
  output logic [2:0]               sr2,
  output logic [5:0]               offset6,
  output logic [8:0]               offset9,
  output logic [10:0]              offset11,
  output logic [7:0]               trapvect8,
  output logic [4:0]               imm5,
  output logic [3:0]               imm4,
  output logic                     bit11,
  output logic                     bit5,
  output logic                     bit4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [15:0]          instr_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [AW-1:0]        head_q, head_d;
  logic [AW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 enq_fire, deq_fire;
  logic [15:0]          head_instr;

  assign enq_ready = (count_q != Full);
  assign deq_valid = (count_q != '0);
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_ready && deq_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (enq_fire) tail_d = tail_q + 1'b1;
      if (deq_fire) head_d = head_q + 1'b1;
      if (enq_fire && !deq_fire) count_d = count_q + 1'b1;
      if (deq_fire && !enq_fire) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count says it is occupied.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      instr_mem_q[tail_q] <= enq_instr;
      pc_mem_q[tail_q]    <= enq_pc;
    end
  end

  assign head_instr = deq_valid ? instr_mem_q[head_q] : '0;
  assign deq_instr  = head_instr;
  assign deq_pc     = deq_valid ? pc_mem_q[head_q] : '0;
  assign count      = count_q;

  assign opcode    = head_instr[15:12];
  assign dest      = head_instr[11:9];
  assign sr1       = head_instr[8:6];
  assign sr2       = head_instr[2:0];
  assign offset6   = head_instr[5:0];
  assign offset9   = head_instr[8:0];
  assign offset11  = head_instr[10:0];
  assign trapvect8 = head_instr[7:0];
  assign imm5      = head_instr[4:0];
  assign imm4      = head_instr[3:0];
  assign bit11     = head_instr[11];
  assign bit5      = head_instr[5];
  assign bit4      = head_instr[4];

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: decode table, directed corner cases, and random
// traffic compared against a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [15:0] enq_instr;
  logic [15:0] enq_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [15:0] deq_instr;
  logic [15:0] deq_pc;
  logic [3:0]  opcode;
  logic [2:0]  dest, sr1, sr2;
  logic [5:0]  offset6;
  logic [8:0]  offset9;
  logic [10:0] offset11;
  logic [7:0]  trapvect8;
  logic [4:0]  imm5;
  logic [3:0]  imm4;
  logic        bit11, bit5, bit4;
  logic [3:0]  count;

  instr_queue #(.DEPTH(DEPTH), .PC_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_instr (enq_instr),
    .enq_pc    (enq_pc),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .opcode    (opcode),
    .dest      (dest),
    .sr1       (sr1),
    .sr2       (sr2),
    .offset6   (offset6),
    .offset9   (offset9),
    .offset11  (offset11),
    .trapvect8 (trapvect8),
    .imm5      (imm5),
    .imm4      (imm4),
    .bit11     (bit11),
    .bit5      (bit5),
    .bit4      (bit4),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    logic [5:0]  off6;
    logic [8:0]  off9;
    logic [10:0] off11;
    logic [7:0]  trap;
    logic [4:0]  imm5;
    logic        b5;
    logic        b11;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the model's head entry by plain arithmetic.
  task automatic check_all();
    int w;
    int p;
    int n;
    n = mq.size();
    w = (n > 0) ? int'(mq[0].instr) : 0;
    p = (n > 0) ? int'(mq[0].pc) : 0;
    chk("deq_valid", 32'(deq_valid), 32'(n != 0));
    chk("enq_ready", 32'(enq_ready), 32'(n != DEPTH));
    chk("count",     32'(count),     n);
    chk("deq_instr", 32'(deq_instr), w);
    chk("deq_pc",    32'(deq_pc),    p);
    chk("opcode",    32'(opcode),    (w / 4096) % 16);
    chk("dest",      32'(dest),      (w / 512) % 8);
    chk("sr1",       32'(sr1),       (w / 64) % 8);
    chk("sr2",       32'(sr2),       w % 8);
    chk("offset6",   32'(offset6),   w % 64);
    chk("offset9",   32'(offset9),   w % 512);
    chk("offset11",  32'(offset11),  w % 2048);
    chk("trapvect8", 32'(trapvect8), w % 256);
    chk("imm5",      32'(imm5),      w % 32);
    chk("imm4",      32'(imm4),      w % 16);
    chk("bit11",     32'(bit11),     (w / 2048) % 2);
    chk("bit5",      32'(bit5),      (w / 32) % 2);
    chk("bit4",      32'(bit4),      (w / 16) % 2);
  endtask

  task automatic cycle(input logic fl, input logic ev, input logic [15:0] ins,
                       input logic [15:0] pc, input logic dr);
    bit   ef;
    bit   df;
    ent_t e;
    flush     = fl;
    enq_valid = ev;
    enq_instr = ins;
    enq_pc    = pc;
    deq_ready = dr;
    ef = ev && (mq.size() != DEPTH);
    df = dr && (mq.size() != 0);
    e.instr = ins;
    e.pc    = pc;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (df) void'(mq.pop_front());
      if (ef) mq.push_back(e);
    end
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'h1283, 4'h1, 3'd1, 3'd2, 3'd3, 6'h03, 9'h083, 11'h283, 8'h83, 5'h03, 1'b0, 1'b0};
    tbl[1] = '{16'h5A7F, 4'h5, 3'd5, 3'd1, 3'd7, 6'h3F, 9'h07F, 11'h27F, 8'h7F, 5'h1F, 1'b1, 1'b1};
    tbl[2] = '{16'hF025, 4'hF, 3'd0, 3'd0, 3'd5, 6'h25, 9'h025, 11'h025, 8'h25, 5'h05, 1'b1, 1'b0};
    tbl[3] = '{16'h0E05, 4'h0, 3'd7, 3'd0, 3'd5, 6'h05, 9'h005, 11'h605, 8'h05, 5'h05, 1'b0, 1'b1};

    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_instr = '0; enq_pc = '0; deq_ready = 1'b0;
    #12;
    chk("rst deq_valid", 32'(deq_valid), 0);
    chk("rst enq_ready", 32'(enq_ready), 1);
    chk("rst count",     32'(count),     0);
    chk("rst opcode",    32'(opcode),    0);
    chk("rst deq_pc",    32'(deq_pc),    0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);  // deq_ready while empty is harmless

    // Decode table: enqueue, check fields next cycle, then dequeue.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, tbl[i].instr, 16'h3000 + 16'(2 * i), 1'b0);
      chk("tbl deq_valid", 32'(deq_valid), 1);
      chk("tbl deq_pc",    32'(deq_pc),    32'(16'h3000 + 16'(2 * i)));
      chk("tbl opcode",    32'(opcode),    32'(tbl[i].op));
      chk("tbl dest",      32'(dest),      32'(tbl[i].dest));
      chk("tbl sr1",       32'(sr1),       32'(tbl[i].sr1));
      chk("tbl sr2",       32'(sr2),       32'(tbl[i].sr2));
      chk("tbl offset6",   32'(offset6),   32'(tbl[i].off6));
      chk("tbl offset9",   32'(offset9),   32'(tbl[i].off9));
      chk("tbl offset11",  32'(offset11),  32'(tbl[i].off11));
      chk("tbl trapvect8", 32'(trapvect8), 32'(tbl[i].trap));
      chk("tbl imm5",      32'(imm5),      32'(tbl[i].imm5));
      chk("tbl bit5",      32'(bit5),      32'(tbl[i].b5));
      chk("tbl bit11",     32'(bit11),     32'(tbl[i].b11));
      cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
      chk("tbl count after deq", 32'(count), 0);
    end

    // Fill to full, then a refused ninth word.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 16'(i), 16'h4000 + 16'(i), 1'b0);
    chk("full count",     32'(count),     8);
    chk("full enq_ready", 32'(enq_ready), 0);
    cycle(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
    chk("full count after 9th", 32'(count),     8);
    chk("full head after 9th",  32'(deq_instr), 0);

    // Full with simultaneous offers: only the dequeue fires.
    cycle(1'b0, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1);
    chk("full+deq count", 32'(count),     7);
    chk("full+deq head",  32'(deq_instr), 1);

    // Drain to 3, then stream through pointer wrap-around.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    chk("drain count", 32'(count), 3);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 16'h0100 + 16'(i), 16'h5000 + 16'(i), 1'b1);
      chk("stream count", 32'(count), 3);
    end

    // Flush with a concurrent enqueue at count 5.
    cycle(1'b0, 1'b1, 16'h0200, 16'h6000, 1'b0);
    cycle(1'b0, 1'b1, 16'h0201, 16'h6001, 1'b0);
    chk("pre-flush count", 32'(count), 5);
    cycle(1'b1, 1'b1, 16'h0202, 16'h6002, 1'b0);
    chk("flush count",     32'(count),     0);
    chk("flush deq_valid", 32'(deq_valid), 0);

    // Refill two entries, then pulse reset between edges.
    cycle(1'b0, 1'b1, 16'h3456, 16'h7000, 1'b0);
    cycle(1'b0, 1'b1, 16'h3457, 16'h7002, 1'b0);
    chk("refill count", 32'(count), 2);
    enq_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("async rst count",     32'(count),     0);
    chk("async rst deq_valid", 32'(deq_valid), 0);
    chk("async rst deq_instr", 32'(deq_instr), 0);
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), 16'($urandom),
            16'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Parametrised instruction queue replacing the single-entry instruction register in the LC-3b fetch/decode path.
- Buffers up to DEPTH fetched instruction words, each with its PC, in FIFO order.
- Presents the head entry together with its decoded LC-3b fields to the decode/dispatch stage.
- Uses a valid/ready handshake on both sides and supports a synchronous flush for branch mispredicts.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- PC_WIDTH, 16, width of the stored PC.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all entries.
- enq_valid  input  1  fetch offers an entry.
- enq_ready  output  1  queue can accept an entry.
- enq_instr  input  16  instruction word (lc3b_word).
- enq_pc  input  PC_WIDTH  PC of the instruction.
- deq_valid  output  1  head entry is valid.
- deq_ready  input  1  decode consumes the head.
- deq_instr  output  16  head instruction word.
- deq_pc  output  PC_WIDTH  head PC.
- opcode  output  4  head bits [15:12] (lc3b_opcode).
- dest, sr1, sr2  output  3 each  head bits [11:9], [8:6], [2:0].
- offset6, offset9, offset11  output  6/9/11  head bits [5:0], [8:0], [10:0].
- trapvect8  output  8  head bits [7:0].
- imm5, imm4  output  5/4  head bits [4:0], [3:0].
- bit11, bit5, bit4  output  1 each  head bits 11, 5, 4.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers:
  - Circular buffer with head pointer, tail pointer and count register.
  - Pointers wrap from DEPTH-1 to 0.
- Reset (rst_n low, asynchronous):
  - head=0, tail=0, count=0.
  - Therefore deq_valid=0, enq_ready=1, and all deq_* and decoded outputs are 0.
  - Storage contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately; no partial enqueue survives.
- Outputs:
  - enq_ready = (count != DEPTH). It does not depend on deq_ready, so a full queue refuses enqueue even when a dequeue happens in the same cycle.
  - deq_valid = (count != 0).
- Handshake:
  - enq fires when enq_valid && enq_ready: word and PC are written at tail, tail advances.
  - deq fires when deq_valid && deq_ready: head advances.
  - enq_instr/enq_pc are ignored when enq does not fire.
  - deq_ready while empty has no effect.
- Count update:
  - +1 on enq only, -1 on deq only.
  - Unchanged when both fire in one cycle (legal whenever 0 < count < DEPTH).
  - Never exceeds DEPTH and never underflows.
- Latency:
  - An entry enqueued at edge N is visible on deq_* at the start of cycle N+1.
  - There is no same-cycle bypass from enq to deq.
- Decoded fields:
  - Combinational slices of the head storage word, using the same bit positions as the existing IR.
  - All deq_* and decoded outputs are forced to 0 while deq_valid=0, so an empty queue gives deterministic outputs.
- Flush:
  - Synchronous and highest priority.
  - At the edge where flush=1: head=tail=0, count=0, and any enq or deq firing that cycle is discarded.
  - enq_ready stays 1 during flush; the producer must not count an entry presented in a flush cycle as accepted.
- Ordering: strict FIFO; entries are never reordered or duplicated.

Test Plan:
- Reset then idle:
  - Drive rst_n=0, then release.
  - Expect deq_valid=0, enq_ready=1, count=0, opcode=0, deq_pc=0.
- Single pass and decode:
  - Enqueue instr 16'h1283 at pc 16'h3000 (ADD R1,R2,R3).
  - Next cycle expect deq_valid=1, opcode=4'h1, dest=1, sr1=2, sr2=3, bit5=0, deq_pc=16'h3000.
  - Dequeue, then expect count=0.
- Fill to full with DEPTH=8:
  - Enqueue 8 words 16'h0000..16'h0007 with deq_ready=0.
  - Expect count=8, enq_ready=0.
  - Offer a 9th word: it is not stored, and the head stays 16'h0000.
- Simultaneous enq/deq:
  - With count=3, hold enq_valid=1 and deq_ready=1 for 10 cycles.
  - Expect count to stay 3 and the output order to match input order across pointer wrap-around.
- Full plus simultaneous deq:
  - At count=8, assert deq_ready=1 and enq_valid=1 together.
  - Expect the deq to fire, the enq not to fire (enq_ready=0), and count=7.
- Flush and async reset mid-stream:
  - With count=5, assert flush together with enq_valid=1.
  - Next cycle expect count=0, deq_valid=0.
  - Refill with 2 entries, then pulse rst_n low between clock edges: count drops to 0 without waiting for a clock edge.
